// File: rtl/lb_stream_fifo.sv
// ---------------------------------------------------------------------------
// lb_stream_fifo
//   Streaming FIFO controller in front of a DEPTH x DW 1R1W line-buffer macro
//   with a registered read port. Beats pushed by the producer are written
//   straight into the macro. A small prefetcher keeps a 2-entry output queue
//   topped up, which hides the macro's 1-cycle read latency so the consumer
//   side can sustain one beat per cycle.
//
// Ports
//   clock, reset            : single clock, asynchronous active-high reset
//   in_valid/in_ready/in_data    : producer valid/ready stream
//   out_valid/out_ready/out_data : consumer valid/ready stream (queue head)
//   count                   : beats held (macro + in-flight read + queue)
//   mem_W0_addr/en/data     : macro write port (driven by this block)
//   mem_R0_addr/en          : macro read port request
//   mem_R0_data             : macro read data, valid the cycle after R0_en
// ---------------------------------------------------------------------------
module lb_stream_fifo #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 128,
    parameter int CW    = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] count,
    output logic [AW-1:0] mem_W0_addr,
    output logic          mem_W0_en,
    output logic [DW-1:0] mem_W0_data,
    output logic [AW-1:0] mem_R0_addr,
    output logic          mem_R0_en,
    input  logic [DW-1:0] mem_R0_data
);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   mem_cnt;     // beats resident in the macro, 0..DEPTH
    logic          inflight;    // a read issued last cycle returns data now
    logic [1:0]    oq_cnt;      // output queue occupancy, 0..2
    logic [DW-1:0] oq0;         // queue head
    logic [DW-1:0] oq1;

    logic          push;
    logic          pop;
    logic          rd_issue;
    logic [2:0]    oq_pend;     // queue slots claimed after this cycle's pop

    // Space check uses registered state only, so in_ready has no path
    // from out_ready.
    assign in_ready  = (mem_cnt < (AW+1)'(DEPTH));
    assign out_valid = (oq_cnt != 2'd0);
    assign out_data  = oq0;

    // Enables are masked while reset is held so nothing reaches the macro
    // during reset even if the producer is still presenting data.
    assign push = in_valid && in_ready && !reset;
    assign pop  = out_valid && out_ready;

    // pop <= oq_cnt, so this never underflows.
    assign oq_pend  = {1'b0, oq_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign rd_issue = (mem_cnt != '0) && (oq_pend < 3'd2) && !reset;

    assign mem_W0_en   = push;
    assign mem_W0_addr = wptr;
    assign mem_W0_data = push ? in_data : '0;
    assign mem_R0_en   = rd_issue;
    assign mem_R0_addr = rptr;

    assign count = CW'(mem_cnt) + CW'(inflight) + CW'(oq_cnt);

    // Pointers and macro occupancy. DEPTH is a power of two, so the AW-bit
    // pointers wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (push)     wptr <= wptr + 1'b1;
            if (rd_issue) rptr <= rptr + 1'b1;
            case ({push, rd_issue})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
            inflight <= rd_issue;
        end
    end

    // Output queue: returning read data is enqueued, head is popped. The
    // prefetch condition guarantees an enqueue never finds the queue full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oq_cnt <= 2'd0;
            oq0    <= '0;
            oq1    <= '0;
        end else begin
            case ({inflight, pop})
                2'b11: begin
                    if (oq_cnt == 2'd1) begin
                        oq0 <= mem_R0_data;
                    end else begin
                        oq0 <= oq1;
                        oq1 <= mem_R0_data;
                    end
                end
                2'b01: begin
                    oq0    <= oq1;
                    oq_cnt <= oq_cnt - 2'd1;
                end
                2'b10: begin
                    if (oq_cnt == 2'd0) oq0 <= mem_R0_data;
                    else                oq1 <= mem_R0_data;
                    oq_cnt <= oq_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lb_stream_fifo.sv
module tb_lb_stream_fifo;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 128;
    localparam int CW    = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic [AW-1:0] mem_W0_addr;
    logic          mem_W0_en;
    logic [DW-1:0] mem_W0_data;
    logic [AW-1:0] mem_R0_addr;
    logic          mem_R0_en;
    logic [DW-1:0] mem_R0_data;

    always #5 clock = ~clock;

    lb_stream_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data),
        .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data)
    );

    // Line-buffer macro: synchronous write, registered read, never cleared.
    logic [DW-1:0] macro_mem [DEPTH];
    always @(posedge clock) begin
        if (mem_W0_en) macro_mem[mem_W0_addr] <= mem_W0_data;
        if (mem_R0_en) mem_R0_data <= macro_mem[mem_R0_addr];
    end

    // Reference model: an ordered list of held beats with their push cycle.
    // A beat becomes visible at the head no earlier than 3 cycles after push.
    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } beat_t;

    beat_t         sb[$];
    int            cyc;
    int            wr_cnt;
    int            rd_cnt;
    int            n_push;
    int            n_pop;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        sb.delete();
        cyc = 0; wr_cnt = 0; rd_cnt = 0; n_push = 0; n_pop = 0;
        prev_stall = 1'b0;
    endtask

    // Apply inputs for one cycle; leaves time at the sample point.
    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy);
        @(negedge clock);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    // Compare the DUT against the model at the sample point, then advance
    // one clock and update the model from the observed handshakes.
    task automatic tick();
        logic          push_s, pop_s, exp_ov, rd_s;
        logic [DW-1:0] d_s;
        exp_ov = (sb.size() > 0) && (sb[0].t <= cyc - 3);
        checks++;
        if (count !== CW'(sb.size()))
            begin errors++; $display("FAIL count cyc=%0d: got %0d expected %0d", cyc, count, sb.size()); end
        checks++;
        if (out_valid !== exp_ov)
            begin errors++; $display("FAIL out_valid cyc=%0d: got %b expected %b", cyc, out_valid, exp_ov); end
        if (exp_ov) begin
            checks++;
            if (out_data !== sb[0].d)
                begin errors++; $display("FAIL out_data cyc=%0d: got %h expected %h", cyc, out_data, sb[0].d); end
        end
        if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data)
                begin errors++; $display("FAIL stall_hold cyc=%0d: got %b/%h expected 1/%h", cyc, out_valid, out_data, prev_data); end
        end
        checks++;
        if ((sb.size() < DEPTH && in_ready !== 1'b1) || (sb.size() >= DEPTH + 2 && in_ready !== 1'b0))
            begin errors++; $display("FAIL in_ready cyc=%0d: got %b with %0d held", cyc, in_ready, sb.size()); end
        push_s = in_valid && in_ready;
        checks++;
        if (mem_W0_en !== push_s)
            begin errors++; $display("FAIL w_en cyc=%0d: got %b expected %b", cyc, mem_W0_en, push_s); end
        if (push_s) begin
            checks++;
            if (mem_W0_addr !== AW'(wr_cnt % DEPTH) || mem_W0_data !== in_data)
                begin errors++; $display("FAIL w_port cyc=%0d: got %0d/%h expected %0d/%h", cyc, mem_W0_addr, mem_W0_data, wr_cnt % DEPTH, in_data); end
        end
        rd_s = (mem_R0_en === 1'b1);
        if (rd_s) begin
            checks++;
            if (mem_R0_addr !== AW'(rd_cnt % DEPTH) || rd_cnt >= wr_cnt)
                begin errors++; $display("FAIL r_port cyc=%0d: got addr %0d expected %0d (writes %0d)", cyc, mem_R0_addr, rd_cnt % DEPTH, wr_cnt); end
        end
        if (sb.size() == 0) begin
            checks++;
            if (mem_R0_en !== 1'b0 || out_valid !== 1'b0)
                begin errors++; $display("FAIL empty cyc=%0d: got r_en %b out_valid %b expected 0 0", cyc, mem_R0_en, out_valid); end
        end
        pop_s      = out_valid && out_ready;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        d_s        = in_data;
        @(posedge clock);
        if (push_s) begin sb.push_back('{d_s, cyc}); wr_cnt++; n_push++; end
        if (pop_s && sb.size() > 0) begin void'(sb.pop_front()); n_pop++; end
        if (rd_s) rd_cnt++;
        cyc++;
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = rnd128();
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== '0)
            begin errors++; $display("FAIL reset_stream: got rdy %b vld %b cnt %0d expected 1 0 0", in_ready, out_valid, count); end
        checks++;
        if (mem_W0_en !== 1'b0 || mem_R0_en !== 1'b0 || mem_W0_addr !== '0 || mem_R0_addr !== '0)
            begin errors++; $display("FAIL reset_mem: got wen %b ren %b wa %0d ra %0d expected 0 0 0 0", mem_W0_en, mem_R0_en, mem_W0_addr, mem_R0_addr); end
        checks++;
        if (mem_W0_data !== '0 || out_data !== '0)
            begin errors++; $display("FAIL reset_data: got %h / %h expected 0", mem_W0_data, out_data); end
        release_reset();
    endtask

    task automatic test_single_beat();
        logic [DW-1:0] a5;
        a5 = {16{8'hA5}};
        drive(1'b1, a5, 1'b1);
        checks++;
        if (mem_W0_en !== 1'b1 || mem_W0_addr !== '0)
            begin errors++; $display("FAIL single_write: got %b/%0d expected 1/0", mem_W0_en, mem_W0_addr); end
        tick();
        drive(1'b0, '0, 1'b1);
        checks++;
        if (mem_R0_en !== 1'b1 || mem_R0_addr !== '0)
            begin errors++; $display("FAIL single_read: got %b/%0d expected 1/0", mem_R0_en, mem_R0_addr); end
        tick();
        drive(1'b0, '0, 1'b1);
        checks++;
        if (out_valid !== 1'b0)
            begin errors++; $display("FAIL single_early: got %b expected 0", out_valid); end
        tick();
        drive(1'b0, '0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== a5)
            begin errors++; $display("FAIL single_out: got %b/%h expected 1/%h", out_valid, out_data, a5); end
        tick();
        drive(1'b0, '0, 1'b1);
        checks++;
        if (count !== '0)
            begin errors++; $display("FAIL single_count: got %0d expected 0", count); end
        tick();
    endtask

    task automatic test_fill_drain();
        int rd0, first_pops;
        n_push = 0;
        rd0 = rd_cnt;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, DW'(i), 1'b0);
            tick();
        end
        checks++;
        if (n_push != DEPTH + 2)
            begin errors++; $display("FAIL fill_accepted: got %0d expected %0d", n_push, DEPTH + 2); end
        drive(1'b0, '0, 1'b0);
        checks++;
        if (count !== CW'(DEPTH + 2) || in_ready !== 1'b0)
            begin errors++; $display("FAIL fill_full: got cnt %0d rdy %b expected 34 0", count, in_ready); end
        checks++;
        if (rd_cnt - rd0 != 2)
            begin errors++; $display("FAIL fill_reads: got %0d expected 2", rd_cnt - rd0); end
        tick();
        n_pop = 0;
        first_pops = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, '0, 1'b1);
            tick();
            if (i == DEPTH + 1) first_pops = n_pop;
        end
        checks++;
        if (first_pops != DEPTH + 2 || count !== '0)
            begin errors++; $display("FAIL drain: got %0d pops cnt %0d expected 34 0", first_pops, count); end
    endtask

    task automatic test_streaming();
        int gaps;
        gaps = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, rnd128(), 1'b1);
            if (i >= 3 && (out_valid !== 1'b1 || count !== CW'(3))) gaps++;
            tick();
        end
        checks++;
        if (gaps != 0)
            begin errors++; $display("FAIL streaming: got %0d gap cycles expected 0", gaps); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1);
            tick();
        end
        checks++;
        if (count !== '0 || sb.size() != 0)
            begin errors++; $display("FAIL stream_drain: got %0d expected 0", count); end
    endtask

    task automatic test_backpressure();
        int maxc;
        maxc = 0;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 65, rnd128(), $urandom_range(0, 1) == 1);
            if (int'(count) > maxc) maxc = int'(count);
            tick();
        end
        checks++;
        if (maxc > DEPTH + 2)
            begin errors++; $display("FAIL bp_max_count: got %0d expected <= 34", maxc); end
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, '0, 1'b1);
            tick();
        end
        checks++;
        if (count !== '0 || sb.size() != 0)
            begin errors++; $display("FAIL bp_drain: got %0d expected 0", count); end
    endtask

    task automatic test_reset_midstream();
        logic [DW-1:0] nd;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, rnd128(), 1'b0);
            tick();
        end
        drive(1'b1, rnd128(), 1'b0);
        checks++;
        if (count !== CW'(10))
            begin errors++; $display("FAIL mid_pre_count: got %0d expected 10", count); end
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== '0 || mem_W0_en !== 1'b0)
            begin errors++; $display("FAIL mid_reset: got vld %b cnt %0d wen %b expected 0 0 0", out_valid, count, mem_W0_en); end
        release_reset();
        nd = rnd128();
        drive(1'b1, nd, 1'b1);
        tick();
        for (int i = 1; i < 3; i++) begin
            drive(1'b0, '0, 1'b1);
            tick();
        end
        drive(1'b0, '0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== nd)
            begin errors++; $display("FAIL mid_new_beat: got %b/%h expected 1/%h", out_valid, out_data, nd); end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            tick();
        end
        checks++;
        if (count !== '0)
            begin errors++; $display("FAIL mid_final: got %0d expected 0", count); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_beat();
        test_fill_drain();
        test_streaming();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case something wedges the stimulus.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
